// File: rtl/mul8su_tile_seq.sv
// mul8su_tile_seq
// Computes an 8x8 product (signed x unsigned when SIGNED_A=1, unsigned x
// unsigned when SIGNED_A=0) by issuing four 4x4 products on one shared tile.
// Each product is shifted and added into a 16-bit accumulator.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_a multiplicand, in_b multiplier
//   out_valid/out_ready result handshake; out_p 16-bit product
//   tile_req/tile_gnt   request/grant for the shared 4x4 tile
//   tile_a, tile_b      tile operands (registered, stable while requesting)
//   tile_a_signed       1 = tile_a is two's complement (su tile)
//   tile_p              combinational tile product for tile_a/tile_b
//   dbg_state           current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid source holds its payload stable until that edge; ready
// may change freely. The tile port uses the same rule with req/gnt, and
// tile_p is sampled on the granting edge.

module mul8su_tile_seq #(
  parameter bit SIGNED_A = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        tile_req,
  input  logic        tile_gnt,
  output logic [3:0]  tile_a,
  output logic [3:0]  tile_b,
  output logic        tile_a_signed,
  input  logic [7:0]  tile_p,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LL   = 3'd1,
    S_LH   = 3'd2,
    S_HL   = 3'd3,
    S_HH   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      r_state;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [15:0] r_acc;
  logic [15:0] r_out_p;
  logic        r_out_valid;
  logic        r_tile_req;
  logic [3:0]  r_tile_a;
  logic [3:0]  r_tile_b;
  logic        r_tile_signed;

  logic        w_fire;
  logic [15:0] w_tile_ext;
  logic [15:0] w_addend;
  logic [15:0] w_acc_sum;

  assign w_fire = r_tile_req & tile_gnt;

  // Low-half tiles are always unsigned, so the registered signedness flag
  // alone decides between sign- and zero-extension.
  assign w_tile_ext = r_tile_signed ? {{8{tile_p[7]}}, tile_p} : {8'h00, tile_p};

  always_comb begin
    w_addend = w_tile_ext;
    case (r_state)
      S_LH, S_HL: w_addend = {w_tile_ext[11:0], 4'h0};
      S_HH:       w_addend = {w_tile_ext[7:0], 8'h00};
      default:    w_addend = w_tile_ext;
    endcase
  end

  // Modulo-2^16 add; the true product always fits in 16 bits.
  assign w_acc_sum = r_acc + w_addend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_a           <= 8'h00;
      r_b           <= 8'h00;
      r_acc         <= 16'h0000;
      r_out_p       <= 16'h0000;
      r_out_valid   <= 1'b0;
      r_tile_req    <= 1'b0;
      r_tile_a      <= 4'h0;
      r_tile_b      <= 4'h0;
      r_tile_signed <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a           <= in_a;
            r_b           <= in_b;
            r_acc         <= 16'h0000;
            r_tile_req    <= 1'b1;
            r_tile_a      <= in_a[3:0];
            r_tile_b      <= in_b[3:0];
            r_tile_signed <= 1'b0;
            r_state       <= S_LL;
          end
        end
        S_LL: begin
          if (w_fire) begin
            r_acc    <= w_acc_sum;
            r_tile_a <= r_a[3:0];
            r_tile_b <= r_b[7:4];
            r_state  <= S_LH;
          end
        end
        S_LH: begin
          if (w_fire) begin
            r_acc         <= w_acc_sum;
            r_tile_a      <= r_a[7:4];
            r_tile_b      <= r_b[3:0];
            r_tile_signed <= SIGNED_A;
            r_state       <= S_HL;
          end
        end
        S_HL: begin
          if (w_fire) begin
            r_acc    <= w_acc_sum;
            r_tile_b <= r_b[7:4];
            r_state  <= S_HH;
          end
        end
        S_HH: begin
          if (w_fire) begin
            // Final partial product goes straight to the output register.
            r_acc         <= w_acc_sum;
            r_out_p       <= w_acc_sum;
            r_out_valid   <= 1'b1;
            r_tile_req    <= 1'b0;
            r_tile_a      <= 4'h0;
            r_tile_b      <= 4'h0;
            r_tile_signed <= 1'b0;
            r_state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_tile_req  <= 1'b0;
        end
      endcase
    end
  end

  // No bypass: a new operand is taken only once the FSM is back in IDLE.
  assign in_ready      = (r_state == S_IDLE);
  assign out_valid     = r_out_valid;
  assign out_p         = r_out_p;
  assign tile_req      = r_tile_req;
  assign tile_a        = r_tile_a;
  assign tile_b        = r_tile_b;
  assign tile_a_signed = r_tile_signed;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_mul8su_tile_seq.sv
// Bench for mul8su_tile_seq. Instance 0 uses SIGNED_A=1, instance 1 uses
// SIGNED_A=0. A behavioural model (plain integer products, per-op tile
// schedule, busy/grant counters) is checked against both instances on every
// falling edge; directed cases add literal expectations.

module tb_mul8su_tile_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid      [2];
  logic        in_ready      [2];
  logic [7:0]  in_a          [2];
  logic [7:0]  in_b          [2];
  logic        out_valid     [2];
  logic        out_ready     [2];
  logic [15:0] out_p         [2];
  logic        tile_req      [2];
  logic        tile_gnt      [2];
  logic [3:0]  tile_a        [2];
  logic [3:0]  tile_b        [2];
  logic        tile_a_signed [2];
  logic [7:0]  tile_p        [2];
  logic [2:0]  dbg_state     [2];

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference functions ----------------
  function automatic logic [7:0] tile_fn(input logic s, input logic [3:0] a, input logic [3:0] b);
    int sa;
    sa = (s && a[3]) ? int'(a) - 16 : int'(a);
    return 8'(sa * int'(b));
  endfunction

  function automatic logic [15:0] model_p(input int d, input logic [7:0] a, input logic [7:0] b);
    int sa;
    sa = (d == 0 && a[7]) ? int'(a) - 256 : int'(a);
    return 16'(sa * int'(b));
  endfunction

  // {signed, tile_a, tile_b} expected for tile k of an operation
  function automatic logic [8:0] exp_tile(input int d, input logic [7:0] a, input logic [7:0] b, input int k);
    logic s;
    s = (d == 0);
    case (k)
      0:       return {1'b0, a[3:0], b[3:0]};
      1:       return {1'b0, a[3:0], b[7:4]};
      2:       return {s,    a[7:4], b[3:0]};
      default: return {s,    a[7:4], b[7:4]};
    endcase
  endfunction

  // ---------------- DUTs and tile models ----------------
  mul8su_tile_seq #(.SIGNED_A(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_p(out_p[0]),
    .tile_req(tile_req[0]), .tile_gnt(tile_gnt[0]), .tile_a(tile_a[0]), .tile_b(tile_b[0]),
    .tile_a_signed(tile_a_signed[0]), .tile_p(tile_p[0]), .dbg_state(dbg_state[0])
  );

  mul8su_tile_seq #(.SIGNED_A(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_p(out_p[1]),
    .tile_req(tile_req[1]), .tile_gnt(tile_gnt[1]), .tile_a(tile_a[1]), .tile_b(tile_b[1]),
    .tile_a_signed(tile_a_signed[1]), .tile_p(tile_p[1]), .dbg_state(dbg_state[1])
  );

  assign tile_p[0] = tile_fn(tile_a_signed[0], tile_a[0], tile_b[0]);
  assign tile_p[1] = tile_fn(tile_a_signed[1], tile_a[1], tile_b[1]);

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [16:0] exp_q[$];          // {dut index, expected product}
  bit          busy      [2];
  int          tile_idx  [2];
  logic [7:0]  cur_a     [2];
  logic [7:0]  cur_b     [2];
  logic [16:0] tlog      [2][4];  // {signed, tile_a, tile_b, tile_p} per grant
  int          stall_cnt [2];
  logic [7:0]  stall_ops [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        busy[d]     = 1'b0;
        tile_idx[d] = 0;
        chk("rst_out_valid", 32'(out_valid[d]), 32'd0);
        chk("rst_in_ready", 32'(in_ready[d]), 32'd1);
        chk("rst_tile_req", 32'(tile_req[d]), 32'd0);
        chk("rst_out_p", 32'(out_p[d]), 32'd0);
        chk("rst_tile_ops", 32'({tile_a_signed[d], tile_a[d], tile_b[d]}), 32'd0);
      end else begin
        chk("in_ready", 32'(in_ready[d]), 32'(!busy[d]));
        chk("tile_req", 32'(tile_req[d]), 32'(busy[d] && tile_idx[d] < 4));
        chk("out_valid", 32'(out_valid[d]), 32'(busy[d] && tile_idx[d] == 4));
        if (out_valid[d]) begin
          if (exp_q.size() == 0) begin
            chk("out_p_no_expect", 32'd1, 32'd0);
          end else begin
            chk("out_p", 32'({1'(d), out_p[d]}), 32'(exp_q[0]));
            if (out_ready[d]) begin
              void'(exp_q.pop_front());
              busy[d] = 1'b0;
            end
          end
        end
        if (tile_req[d] && tile_idx[d] < 4) begin
          chk("tile_ops", 32'({tile_a_signed[d], tile_a[d], tile_b[d]}),
              32'(exp_tile(d, cur_a[d], cur_b[d], tile_idx[d])));
          if (tile_gnt[d]) begin
            tlog[d][tile_idx[d]] = {tile_a_signed[d], tile_a[d], tile_b[d], tile_p[d]};
            tile_idx[d]++;
          end else if (tile_idx[d] == 1) begin
            stall_cnt[d]++;
            stall_ops[d] = {tile_a[d], tile_b[d]};
          end
        end
        if (in_valid[d] && in_ready[d]) begin
          exp_q.push_back({1'(d), model_p(d, in_a[d], in_b[d])});
          busy[d]      = 1'b1;
          tile_idx[d]  = 0;
          cur_a[d]     = in_a[d];
          cur_b[d]     = in_b[d];
          stall_cnt[d] = 0;
        end
      end
    end
    if (!rst_n) exp_q.delete();
  end

  // ---------------- grant / out_ready drivers ----------------
  bit gnt_rand   [2];
  int stall_left [2];
  int ready_mode [2];   // 0 = hold low, 1 = hold high, 2 = random

  initial begin
    for (int d = 0; d < 2; d++) begin
      tile_gnt[d]  = 1'b1;
      out_ready[d] = 1'b1;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (stall_left[d] > 0 && tile_idx[d] == 1 && tile_req[d]) begin
          tile_gnt[d] = 1'b0;
          stall_left[d]--;
        end else begin
          tile_gnt[d] = gnt_rand[d] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        case (ready_mode[d])
          0:       out_ready[d] = 1'b0;
          1:       out_ready[d] = 1'b1;
          default: out_ready[d] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns #1 after the edge that accepted the operands.
  task automatic accept_op(input int d, input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b1;
    in_a[d]     = a;
    in_b[d]     = b;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready[d];
      @(posedge clk);
      #1;
    end
    in_valid[d] = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // lat = edges from the accept edge to the result-accept edge;
  // first_v = edges after which out_valid was first seen high.
  task automatic wait_result(input int d, output logic [15:0] p, output int lat, output int first_v);
    bit hs;
    hs      = 1'b0;
    lat     = 0;
    first_v = -1;
    p       = 16'hxxxx;
    while (!hs && lat < 400) begin
      @(negedge clk);
      if (out_valid[d] && first_v < 0) first_v = lat;
      if (out_valid[d] && out_ready[d]) begin
        hs = 1'b1;
        p  = out_p[d];
      end
      @(posedge clk);
      #1;
      lat++;
    end
    if (!hs) chk("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int lat, output int first_v);
    accept_op(d, a, b);
    wait_result(d, p, lat, first_v);
  endtask

  // ---------------- main sequence ----------------
  logic [15:0] p;
  int          lat;
  int          fv;
  bit          idx_ok;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]   = 1'b0;
      in_a[d]       = 8'h00;
      in_b[d]       = 8'h00;
      gnt_rand[d]   = 1'b0;
      stall_left[d] = 0;
      ready_mode[d] = 1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Largest positive product, latency with grant/ready tied high
    run_op(0, 8'h7F, 8'hFF, p, lat, fv);
    chk("p_7f_ff", 32'(p), 32'h7E81);
    chk("lat_accept_edge", 32'(lat), 32'd5);
    chk("lat_first_valid", 32'(fv), 32'd4);

    // Most negative product and its tile schedule
    run_op(0, 8'h80, 8'hFF, p, lat, fv);
    chk("p_80_ff", 32'(p), 32'h8080);
    chk("tile_ll", 32'(tlog[0][0]), 32'h00F00);
    chk("tile_lh", 32'(tlog[0][1]), 32'h00F00);
    chk("tile_hl", 32'(tlog[0][2]), 32'h18F88);
    chk("tile_hh", 32'(tlog[0][3]), 32'h18F88);

    // Sign extension with output backpressure; junk inputs while busy
    ready_mode[0] = 0;
    accept_op(0, 8'hFF, 8'h01);
    in_valid[0] = 1'b1;
    in_a[0]     = 8'h11;
    in_b[0]     = 8'h22;
    repeat (5) @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_out_p", 32'(out_p[0]), 32'hFFFF);
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid[0]   = 1'b0;
    ready_mode[0] = 1;
    out_ready[0]  = 1'b1;
    wait_result(0, p, lat, fv);
    chk("bp_result", 32'(p), 32'hFFFF);
    chk("bp_first_ready_edge", 32'(lat), 32'd1);
    @(negedge clk);
    chk("bp_in_ready_after", 32'(in_ready[0]), 32'd1);

    // Grant withheld for 3 cycles in the LH tile
    stall_left[0] = 3;
    run_op(0, 8'h35, 8'h2C, p, lat, fv);
    chk("p_35_2c", 32'(p), 32'h091C);
    chk("stall_lat", 32'(lat), 32'd8);
    chk("stall_cycles", 32'(stall_cnt[0]), 32'd3);
    chk("stall_ops", 32'(stall_ops[0]), 32'h52);

    // Reset in the HL tile aborts the operation
    accept_op(0, 8'h9A, 8'h57);
    idx_ok = 1'b0;
    for (int n = 0; n < 20 && !idx_ok; n++) begin
      if (tile_idx[0] == 2) idx_ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("reach_hl", 32'(idx_ok), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("mid_rst_tile_req", 32'(tile_req[0]), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
    chk("mid_rst_tile_ops", 32'({tile_a_signed[0], tile_a[0], tile_b[0]}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    run_op(0, 8'h02, 8'h03, p, lat, fv);
    chk("p_02_03", 32'(p), 32'h0006);

    // Randomized signed traffic with random grants and backpressure
    gnt_rand[0]   = 1'b1;
    ready_mode[0] = 2;
    for (int i = 0; i < 40; i++) begin
      run_op(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), p, lat, fv);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    gnt_rand[0]   = 1'b0;
    ready_mode[0] = 1;

    // Unsigned instance
    run_op(1, 8'hC8, 8'hFF, p, lat, fv);
    chk("u_p_c8_ff", 32'(p), 32'hC738);
    chk("u_signed_flags", 32'({tlog[1][0][16], tlog[1][1][16], tlog[1][2][16], tlog[1][3][16]}), 32'd0);
    gnt_rand[1]   = 1'b1;
    ready_mode[1] = 2;
    for (int i = 0; i < 40; i++) begin
      run_op(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), p, lat, fv);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    gnt_rand[1]   = 1'b0;
    ready_mode[1] = 1;

    repeat (5) @(posedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
